// File: rtl/frame_scan_renderer.sv
`default_nettype none
// ============================================================================
//  Module   : frame_scan_renderer
//  Purpose  : Walks every (x,y) of a WIDTH x HEIGHT framebuffer once per pass
//             and emits x/y/colour/plot for the VGA adapter. A frame is an
//             optional clear pass followed by a draw pass. The draw pass
//             composites NUM_SPR square sprites over the bullet grid.
//  Ports    : clk, resetn (sync, active low)
//             start, clear_first                 - frame request
//             spr_en/spr_x/spr_y/spr_colour      - packed sprite inputs
//             grid                               - bullet bitmap, bit y*WIDTH+x
//             x, y, colour, plot                 - registered pixel stream
//             busy, frame_done                   - frame status
//  Revision : 1.0  initial release
// ============================================================================
module frame_scan_renderer #(
    parameter int            WIDTH    = 160,
    parameter int            HEIGHT   = 120,
    parameter int            XW       = 8,
    parameter int            YW       = 7,
    parameter int            CW       = 3,
    parameter int            NUM_SPR  = 2,
    parameter int            SPR_SIZE = 1,
    parameter logic [CW-1:0] GRID_CW  = 3'b010,
    parameter logic [CW-1:0] BG_CW    = 3'b000
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    start,
    input  logic                    clear_first,
    input  logic [NUM_SPR-1:0]      spr_en,
    input  logic [NUM_SPR*XW-1:0]   spr_x,
    input  logic [NUM_SPR*YW-1:0]   spr_y,
    input  logic [NUM_SPR*CW-1:0]   spr_colour,
    input  logic [WIDTH*HEIGHT-1:0] grid,
    output logic [XW-1:0]           x,
    output logic [YW-1:0]           y,
    output logic [CW-1:0]           colour,
    output logic                    plot,
    output logic                    busy,
    output logic                    frame_done
);

    localparam int            c_GIW    = (WIDTH * HEIGHT > 1) ? $clog2(WIDTH * HEIGHT) : 1;
    localparam logic [XW-1:0] c_XMAX   = XW'(WIDTH - 1);
    localparam logic [YW-1:0] c_YMAX   = YW'(HEIGHT - 1);
    localparam logic [XW:0]   c_SZX    = (XW + 1)'(SPR_SIZE);
    localparam logic [YW:0]   c_SZY    = (YW + 1)'(SPR_SIZE);
    localparam logic [c_GIW-1:0] c_WG  = c_GIW'(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DRAW  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [XW-1:0]         r_cx;
    logic [YW-1:0]         r_cy;
    logic [XW-1:0]         r_x;
    logic [YW-1:0]         r_y;
    logic [CW-1:0]         r_colour;
    logic                  r_plot;

    // Sprite snapshot taken when a start is accepted, so the frame never tears.
    logic [NUM_SPR-1:0]    r_spr_en;
    logic [NUM_SPR*XW-1:0] r_spr_x;
    logic [NUM_SPR*YW-1:0] r_spr_y;
    logic [NUM_SPR*CW-1:0] r_spr_col;

    logic                  w_accept;
    logic                  w_scan;
    logic                  w_last;
    logic [NUM_SPR-1:0]    w_hit;
    logic [CW-1:0]         w_spr_col;
    logic [CW-1:0]         w_pix_col;
    logic [c_GIW-1:0]      w_gidx;

    assign w_accept   = (r_state == ST_IDLE) && start;
    assign w_scan     = (r_state == ST_CLEAR) || (r_state == ST_DRAW);
    assign w_last     = (r_cx == c_XMAX) && (r_cy == c_YMAX);
    assign w_gidx     = c_GIW'(r_cy) * c_WG + c_GIW'(r_cx);

    assign x          = r_x;
    assign y          = r_y;
    assign colour     = r_colour;
    assign plot       = r_plot;
    assign busy       = (r_state != ST_IDLE);
    assign frame_done = (r_state == ST_DONE);

    // Hit test is done one bit wider than the coordinates so a sprite near the
    // right/bottom edge clips instead of wrapping back to column/row 0.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SPR; gi++) begin : g_spr
            logic [XW:0] w_sx;
            logic [YW:0] w_sy;
            assign w_sx      = {1'b0, r_spr_x[gi*XW +: XW]};
            assign w_sy      = {1'b0, r_spr_y[gi*YW +: YW]};
            assign w_hit[gi] = r_spr_en[gi]
                             && ({1'b0, r_cx} >= w_sx) && ({1'b0, r_cx} < (w_sx + c_SZX))
                             && ({1'b0, r_cy} >= w_sy) && ({1'b0, r_cy} < (w_sy + c_SZY));
        end
    endgenerate

    // Walk from highest to lowest index so the lowest-index hit wins.
    always_comb begin
        w_spr_col = BG_CW;
        for (int i = NUM_SPR - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_spr_col = r_spr_col[i*CW +: CW];
            end
        end
    end

    always_comb begin
        w_pix_col = BG_CW;
        if (r_state == ST_DRAW) begin
            if (|w_hit) begin
                w_pix_col = w_spr_col;
            end else if (grid[w_gidx]) begin
                w_pix_col = GRID_CW;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_nxt = clear_first ? ST_CLEAR : ST_DRAW;
            ST_CLEAR: if (w_last) w_state_nxt = ST_DRAW;
            ST_DRAW:  if (w_last) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= ST_IDLE;
            r_cx      <= '0;
            r_cy      <= '0;
            r_x       <= '0;
            r_y       <= '0;
            r_colour  <= BG_CW;
            r_plot    <= 1'b0;
            r_spr_en  <= '0;
            r_spr_x   <= '0;
            r_spr_y   <= '0;
            r_spr_col <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_spr_en  <= spr_en;
                r_spr_x   <= spr_x;
                r_spr_y   <= spr_y;
                r_spr_col <= spr_colour;
            end
            if (w_scan) begin
                r_x      <= r_cx;
                r_y      <= r_cy;
                r_colour <= w_pix_col;
                r_plot   <= 1'b1;
                // Counters wrap to (0,0) after the last pixel so the next pass
                // (or the next frame) starts from the origin with no gap.
                if (r_cx == c_XMAX) begin
                    r_cx <= '0;
                    r_cy <= (r_cy == c_YMAX) ? '0 : r_cy + 1'b1;
                end else begin
                    r_cx <= r_cx + 1'b1;
                end
            end else begin
                r_plot <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
